cp0_exc_ctrl: RTL and testbench
===============================

// Module: cp0_exc_ctrl
// PURPOSE
// Exception/interrupt commit sequencer between the MEM stage and cp0. Each cycle it selects the
// highest-priority event from the MEM-stage exception vector, synchronised int_i and the timer match.
// It issues one registered write strobe into cp0 (code, EPC, BD, BadVAddr, EXL set/clear) and raises flush.
// It then holds a redirect PC to fetch until fetch accepts it.
// PARAMETERS
// EXC_VECTOR   32'hBFC0_0380  redirect target for all exceptions and interrupts
// SYNC_STAGES  2              flop depth of the int_i synchroniser (>=2)
// PORTS
// clk                 in   1   single clock; all state on posedge clk
// rst                 in   1   reset, asynchronous, active-low
// inst_valid_i        in   1   MEM stage holds a real instruction (not a bubble)
// stall_i             in   1   MEM stage stalled; no event may be accepted this cycle
// exception_type_i    in   32  MEM exception vector: [31] ADEL-fetch [30] RI [29] OV [28] BP [27] SYS [26] ADEL-data [25] ADES [0] ERET
// pc_i                in   32  PC of the MEM-stage instruction
// exception_addr_i    in   32  faulting data address for [26]/[25]
// now_in_delayslot_i  in   1   MEM instruction sits in a branch delay slot
// int_i               in   6   asynchronous hardware interrupt lines
// timer_irq_i         in   1   count==compare && compare!=0, from cp0
// status_im_i         in   8   cp0 Status[15:8]
// status_ie_i         in   1   cp0 Status[0]
// status_exl_i        in   1   cp0 Status[EXL]
// epc_i               in   32  current cp0 EPC (ERET target)
// redirect_ready_i    in   1   fetch accepts redirect this cycle
// cause_ip_o          out  6   synchronised int_i, to cp0 Cause[15:10]
// exc_we_o            out  1   one-cycle commit strobe into cp0
// exc_code_o          out  5   ExcCode to write into Cause[6:2]
// exc_epc_we_o        out  1   EPC/BD write enable (exc_we_o && !EXL at sample)
// exc_epc_o           out  32  EPC value
// exc_bd_o            out  1   Cause[BD] value
// exc_badvaddr_we_o   out  1   BadVAddr write enable
// exc_badvaddr_o      out  32  BadVAddr value
// eret_o              out  1   one-cycle strobe: clear EXL (concurrent with redirect)
// flush_o             out  1   flush IF..MEM
// redirect_valid_o    out  1   redirect request to fetch
// redirect_pc_o       out  32  redirect target
// busy_o              out  1   state != IDLE
// BEHAVIOUR
// - Reset (async, rst==0): state=IDLE; every output 0; synchroniser flops 0. Reset mid-REDIRECT aborts it silently.
// - Accept in IDLE only, when inst_valid_i && !stall_i; events in COMMIT/REDIRECT are ignored (already flushed).
// - Interrupt pending: (({cause_ip,timer_irq}&status_im_i[7:2])!=0) && status_ie_i && !status_exl_i;
//   timer_irq_i maps to IP7 and is ORed into cause_ip bit 5.
// - Priority: INT > [31] > [30] > [29] > [28] > [27] > [26] > [25] > [0] ERET.
//   Codes: INT/ADEL/RI/OV/BP/SYS/ADES use the shared EXCEP_CODE_* constants.
// - EPC = now_in_delayslot_i ? pc_i-4 : pc_i (32-bit wrap); BD = now_in_delayslot_i. The same rule applies to INT
//   (the MEM instruction is not committed).
// - BadVAddr: [31] -> pc_i; [26]/[25] -> exception_addr_i; else no write.
// - Synchronous exception with status_exl_i=1: code is still written and the redirect still happens;
//   exc_epc_we_o=0, so EPC and BD are unchanged.
// - ERET: no exc_we_o; eret_o pulse; redirect_pc_o = epc_i sampled at accept.
// - FSM. Decision is registered, so outputs appear the cycle after accept (latency 1):
//     IDLE    -> COMMIT on accept.
//     COMMIT  (1 cycle): exc_we_o/eret_o pulse, flush_o=1, redirect_valid_o=1;
//             -> IDLE if redirect_ready_i, else -> REDIRECT.
//     REDIRECT: flush_o=1, redirect_valid_o=1, redirect_pc_o stable; -> IDLE on redirect_ready_i.
// - flush_o and redirect_valid_o drop the cycle after the handshake. No new accept occurs in that
//   handshake cycle (state != IDLE at sampling).
// - Handshake: redirect_valid_o never drops and redirect_pc_o never changes until redirect_ready_i=1.
// STRUCTURE
// - defines.vh: add EXC_BIT_* indices (31,30,29,28,27,26,25,0) and FSM encodings
//   CEC_IDLE/CEC_COMMIT/CEC_REDIRECT beside the existing EXCEP_CODE_*, EXL, BD.
// - Sub-module cp0_int_sync: SYNC_STAGES-deep flop chain per int_i bit, async active-low clear.
// - Rest: priority encoder (combinational) + registered commit bundle + 3-state FSM.
// TESTING
// 1 OV at pc_i=32'hBFC0_1000, not in delay slot, EXL=0 -> next cycle exc_we_o=1, code=OV,
//   exc_epc_o=32'hBFC0_1000, bd=0, redirect_pc_o=32'hBFC0_0380.
// 2 SYS+RI together, delayslot=1, pc_i=32'h8000_0104 -> code=RI, epc=32'h8000_0100, bd=1.
// 3 ADES addr 32'h0000_0003 with EXL=1 -> exc_we_o=1, exc_epc_we_o=0, badvaddr=32'h3, redirect still issued.
// 4 int_i[2]=1 async, IM[4]=1, IE=1 -> cause_ip_o[2] after SYNC_STAGES cycles, then INT commit.
//   With IE=0 no commit occurs.
// 5 ERET with epc_i=32'hBFC0_2000, redirect_ready_i low 5 cycles -> redirect held stable 6 cycles,
//   eret_o pulses once, flush_o drops after the handshake.
// 6 rst low during REDIRECT -> all outputs 0 immediately; after release an exception commits normally.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: shared ExcCodes, exception-vector bit indices and sequencer states
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXCEP_CODE_INT  = 5'h00;
    localparam logic [4:0] EXCEP_CODE_ADEL = 5'h04;
    localparam logic [4:0] EXCEP_CODE_ADES = 5'h05;
    localparam logic [4:0] EXCEP_CODE_SYS  = 5'h08;
    localparam logic [4:0] EXCEP_CODE_BP   = 5'h09;
    localparam logic [4:0] EXCEP_CODE_RI   = 5'h0a;
    localparam logic [4:0] EXCEP_CODE_OV   = 5'h0c;

    localparam int EXC_BIT_ADEL_F = 31;
    localparam int EXC_BIT_RI     = 30;
    localparam int EXC_BIT_OV     = 29;
    localparam int EXC_BIT_BP     = 28;
    localparam int EXC_BIT_SYS    = 27;
    localparam int EXC_BIT_ADEL_D = 26;
    localparam int EXC_BIT_ADES   = 25;
    localparam int EXC_BIT_ERET   = 0;

    typedef enum logic [1:0] {CEC_IDLE, CEC_COMMIT, CEC_REDIRECT} cec_state_t;

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// cp0_int_sync: STAGES-deep synchroniser for asynchronous interrupt lines
// Ports: clk, rst_n (async active-low clear), d (async lines in), q (synchronised out)
module cp0_int_sync #(
    parameter int STAGES = 2,
    parameter int W      = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] chain;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};

    assign q = chain[STAGES-1];
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: MEM-stage exception/interrupt commit sequencer into cp0 with held fetch redirect
// Ports: clk, rst_n (async active-low); MEM inputs inst_valid_i, stall_i, exception_type_i, pc_i,
// exception_addr_i, now_in_delayslot_i; int_i/timer_irq_i and cp0 Status fields; epc_i;
// redirect_ready_i. Outputs: cause_ip_o, cp0 commit bundle exc_*_o, eret_o, flush_o,
// redirect_valid_o/redirect_pc_o handshake, busy_o.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] exception_addr_i,
    input  logic        now_in_delayslot_i,
    input  logic [5:0]  int_i,
    input  logic        timer_irq_i,
    input  logic [7:0]  status_im_i,
    input  logic        status_ie_i,
    input  logic        status_exl_i,
    input  logic [31:0] epc_i,
    input  logic        redirect_ready_i,
    output logic [5:0]  cause_ip_o,
    output logic        exc_we_o,
    output logic [4:0]  exc_code_o,
    output logic        exc_epc_we_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic        exc_badvaddr_we_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        eret_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);
    cec_state_t  state;
    logic [5:0]  ip_sync;
    logic [31:0] e;
    logic        int_pend, is_exc, is_eret, bad_we, accept;
    logic [4:0]  code;

    cp0_int_sync #(.STAGES(SYNC_STAGES), .W(6)) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (int_i),
        .q    (ip_sync)
    );

    // timer match is IP7, sharing Cause bit 15 with hardware line 5
    assign cause_ip_o = {ip_sync[5] | timer_irq_i, ip_sync[4:0]};
    assign e          = exception_type_i;
    assign busy_o     = state != CEC_IDLE;

    always_comb begin
        int_pend = |(cause_ip_o & status_im_i[7:2]) && status_ie_i && !status_exl_i;
        is_exc   = int_pend || |e[EXC_BIT_ADEL_F:EXC_BIT_ADES];
        is_eret  = !is_exc && e[EXC_BIT_ERET];
        code     = int_pend         ? EXCEP_CODE_INT  :
                   e[EXC_BIT_ADEL_F] ? EXCEP_CODE_ADEL :
                   e[EXC_BIT_RI]     ? EXCEP_CODE_RI   :
                   e[EXC_BIT_OV]     ? EXCEP_CODE_OV   :
                   e[EXC_BIT_BP]     ? EXCEP_CODE_BP   :
                   e[EXC_BIT_SYS]    ? EXCEP_CODE_SYS  :
                   e[EXC_BIT_ADEL_D] ? EXCEP_CODE_ADEL : EXCEP_CODE_ADES;
        // BadVAddr only when the winning cause is an address error
        bad_we   = !int_pend && (e[EXC_BIT_ADEL_F] ||
                   (!(e[EXC_BIT_RI] || e[EXC_BIT_OV] || e[EXC_BIT_BP] || e[EXC_BIT_SYS]) &&
                    (e[EXC_BIT_ADEL_D] || e[EXC_BIT_ADES])));
        accept   = state == CEC_IDLE && inst_valid_i && !stall_i && (is_exc || is_eret);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= CEC_IDLE;
            exc_we_o          <= 1'b0;
            exc_code_o        <= '0;
            exc_epc_we_o      <= 1'b0;
            exc_epc_o         <= '0;
            exc_bd_o          <= 1'b0;
            exc_badvaddr_we_o <= 1'b0;
            exc_badvaddr_o    <= '0;
            eret_o            <= 1'b0;
            flush_o           <= 1'b0;
            redirect_valid_o  <= 1'b0;
            redirect_pc_o     <= '0;
        end else begin
            exc_we_o          <= 1'b0;
            eret_o            <= 1'b0;
            exc_epc_we_o      <= 1'b0;
            exc_badvaddr_we_o <= 1'b0;
            case (state)
                CEC_IDLE: if (accept) begin
                    state             <= CEC_COMMIT;
                    exc_we_o          <= is_exc;
                    eret_o            <= is_eret;
                    exc_code_o        <= code;
                    exc_epc_we_o      <= is_exc && !status_exl_i;
                    exc_epc_o         <= now_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    exc_bd_o          <= now_in_delayslot_i;
                    exc_badvaddr_we_o <= bad_we;
                    exc_badvaddr_o    <= e[EXC_BIT_ADEL_F] ? pc_i : exception_addr_i;
                    flush_o           <= 1'b1;
                    redirect_valid_o  <= 1'b1;
                    redirect_pc_o     <= is_eret ? epc_i : EXC_VECTOR;
                end
                default: if (redirect_ready_i) begin
                    state            <= CEC_IDLE;
                    flush_o          <= 1'b0;
                    redirect_valid_o <= 1'b0;
                end else begin
                    state <= CEC_REDIRECT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: scoreboard bench for cp0_exc_ctrl with a transaction-level reference model
module tb_cp0_exc_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        inst_valid, stall, delay, timer, ie, exl, ready;
    logic [31:0] exc, pc, addr, epc;
    logic [5:0]  int_l;
    logic [7:0]  im;
    logic [5:0]  cause_ip_o;
    logic        exc_we_o, exc_epc_we_o, exc_bd_o, exc_badvaddr_we_o, eret_o;
    logic        flush_o, redirect_valid_o, busy_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o, exc_badvaddr_o, redirect_pc_o;

    typedef struct {
        bit          eret;
        logic [4:0]  code;
        bit          epc_we;
        logic [31:0] epc;
        bit          bd;
        bit          bad_we;
        logic [31:0] bad;
        logic [31:0] pc;
    } rec_t;

    rec_t        cq[$];
    bit          rvq[$];
    int          n_vec = 0, n_err = 0;
    bit          busy = 0;
    logic [5:0]  h0 = '0, h1 = '0;
    logic [31:0] last_pc = '0;

    // priority order after INT, with the MIPS ExcCode of each cause
    int          pri_bit[7]  = '{31, 30, 29, 28, 27, 26, 25};
    logic [4:0]  pri_code[7] = '{5'd4, 5'd10, 5'd12, 5'd9, 5'd8, 5'd4, 5'd5};

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .inst_valid_i(inst_valid), .stall_i(stall),
        .exception_type_i(exc), .pc_i(pc), .exception_addr_i(addr), .now_in_delayslot_i(delay),
        .int_i(int_l), .timer_irq_i(timer), .status_im_i(im), .status_ie_i(ie),
        .status_exl_i(exl), .epc_i(epc), .redirect_ready_i(ready), .cause_ip_o(cause_ip_o),
        .exc_we_o(exc_we_o), .exc_code_o(exc_code_o), .exc_epc_we_o(exc_epc_we_o),
        .exc_epc_o(exc_epc_o), .exc_bd_o(exc_bd_o), .exc_badvaddr_we_o(exc_badvaddr_we_o),
        .exc_badvaddr_o(exc_badvaddr_o), .eret_o(eret_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_valid = 0; stall = 0; delay = 0; timer = 0; ie = 0; exl = 0; ready = 1;
        exc = '0; pc = '0; addr = '0; epc = '0; int_l = '0; im = '0;
    endtask

    // one cycle: predict the decision at the coming edge, then advance
    task automatic step();
        rec_t       r;
        logic [5:0] ip;
        bit         pend, acc, nb;
        int         sel;
        ip   = h1 | {timer, 5'b0};
        pend = ((ip & im[7:2]) != 0) && ie && !exl;
        sel  = -1;
        for (int i = 0; i < 7; i++) if (sel < 0 && exc[pri_bit[i]]) sel = i;
        acc  = !busy && inst_valid && !stall && (pend || sel >= 0 || exc[0]);
        if (acc) begin
            r.eret   = !pend && sel < 0;
            r.code   = pend ? 5'd0 : (sel >= 0 ? pri_code[sel] : 5'd0);
            r.epc_we = !r.eret && !exl;
            r.epc    = delay ? pc - 32'd4 : pc;
            r.bd     = delay;
            r.bad_we = !pend && sel >= 0 && (pri_bit[sel] == 31 || pri_bit[sel] == 26 || pri_bit[sel] == 25);
            r.bad    = (sel >= 0 && pri_bit[sel] == 31) ? pc : addr;
            r.pc     = r.eret ? epc : 32'hBFC0_0380;
            cq.push_back(r);
        end
        nb = acc ? 1'b1 : (busy && !ready ? 1'b1 : 1'b0);
        rvq.push_back(nb);
        @(posedge clk);
        busy = nb;
        h1 = h0;
        h0 = int_l;
        #1 check("cause_ip", {26'b0, cause_ip_o}, {26'b0, h1[5] | timer, h1[4:0]});
        #1;
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs", {31'b0, |{cause_ip_o, exc_we_o, exc_code_o, exc_epc_we_o, exc_epc_o,
              exc_bd_o, exc_badvaddr_we_o, exc_badvaddr_o, eret_o, flush_o, redirect_valid_o,
              redirect_pc_o, busy_o}}, 32'd0);
    endtask

    task automatic release_reset();
        rst_n = 1;
        rvq.push_back(1'b0);
    endtask

    always @(negedge clk) if (rst_n) begin
        rec_t r;
        if (rvq.size() != 0) begin
            bit ev;
            ev = rvq.pop_front();
            check("redirect_valid", {31'b0, redirect_valid_o}, {31'b0, ev});
            check("flush", {31'b0, flush_o}, {31'b0, ev});
            check("busy", {31'b0, busy_o}, {31'b0, ev});
        end
        if (exc_we_o || eret_o) begin
            if (cq.size() == 0) begin
                check("unexpected_strobe", {30'b0, exc_we_o, eret_o}, 32'd0);
            end else begin
                r = cq.pop_front();
                check("exc_we", {31'b0, exc_we_o}, {31'b0, !r.eret});
                check("eret", {31'b0, eret_o}, {31'b0, r.eret});
                check("epc_we", {31'b0, exc_epc_we_o}, {31'b0, r.epc_we});
                check("badvaddr_we", {31'b0, exc_badvaddr_we_o}, {31'b0, r.bad_we});
                if (!r.eret) check("exc_code", {27'b0, exc_code_o}, {27'b0, r.code});
                if (r.epc_we) check("epc", exc_epc_o, r.epc);
                if (r.epc_we) check("bd", {31'b0, exc_bd_o}, {31'b0, r.bd});
                if (r.bad_we) check("badvaddr", exc_badvaddr_o, r.bad);
                last_pc = r.pc;
            end
        end
        if (redirect_valid_o) check("redirect_pc", redirect_pc_o, last_pc);
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        #1 release_reset();
        step();
        // OV, not in a delay slot
        inst_valid = 1; exc = 32'h2000_0000; pc = 32'hBFC0_1000;
        step();
        idle_inputs(); repeat (3) step();
        // SYS+RI in a delay slot: RI wins, EPC backs up one word
        inst_valid = 1; exc = 32'h4800_0000; delay = 1; pc = 32'h8000_0104;
        step();
        idle_inputs(); repeat (3) step();
        // ADES with EXL set: code and BadVAddr written, EPC not
        inst_valid = 1; exc = 32'h0200_0000; addr = 32'h0000_0003; exl = 1; pc = 32'h8000_0200;
        step();
        idle_inputs(); repeat (3) step();
        // interrupt on line 2: synchronised first, blocked while IE=0, then taken
        int_l = 6'b000100; im = 8'h10; ie = 0; inst_valid = 1; pc = 32'h8000_0300;
        repeat (4) step();
        ie = 1;
        step();
        idle_inputs(); repeat (4) step();
        // ERET with fetch stalling five cycles; later events and epc changes are ignored
        inst_valid = 1; exc = 32'h1; epc = 32'hBFC0_2000; ready = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            exc = 32'h2000_0001; epc = $urandom;
            step();
        end
        idle_inputs();
        repeat (3) step();
        // reset while a redirect is held
        inst_valid = 1; exc = 32'h1000_0000; pc = 32'h8000_0400; ready = 0;
        repeat (3) step();
        idle_inputs(); ready = 0;
        rst_n = 0;
        #1 check_reset_outputs();
        cq.delete(); rvq.delete(); busy = 0; h0 = '0; h1 = '0;
        repeat (2) @(posedge clk);
        #2 release_reset();
        inst_valid = 1; exc = 32'h0800_0000; pc = 32'h0000_0000; delay = 1;
        step();
        idle_inputs(); repeat (3) step();
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            inst_valid = $urandom_range(0, 3) != 0;
            stall      = $urandom_range(0, 3) == 0;
            exc        = $urandom_range(0, 9) < 4 ? ($urandom & 32'hFE00_0001) : 32'h0;
            if ($urandom_range(0, 7) == 0) exc = 32'h1;
            pc         = $urandom_range(0, 15) == 0 ? 32'h0 : $urandom;
            addr       = $urandom;
            delay      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) int_l = 6'($urandom);
            timer      = $urandom_range(0, 19) == 0;
            im         = 8'($urandom);
            ie         = $urandom_range(0, 1) == 1;
            exl        = $urandom_range(0, 3) == 0;
            epc        = $urandom;
            ready      = $urandom_range(0, 1) == 1;
            step();
        end
        idle_inputs(); repeat (4) step();
        check("queue_drained", cq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
